sector_ring_buffer: RTL and testbench
=====================================

Name: sector_ring_buffer

Overview:
Multi-slot sector buffer between the SD card controller and the core-side disk interface. It replaces the single shared sector DPRAM with a ring of SLOTS sector buffers so the SD side can prefetch further sectors while the core is still consuming the current one. The write side is a sequential byte stream with auto-incrementing address and commits whole sectors. The read side has random access within the oldest committed sector, and releases that sector explicitly when done.

Parameters:
SLOTS, 4, number of sector slots; power of two, at least 2
SECTOR_BYTES, 512, bytes per sector; power of two
DATA_W, 8, data width per word

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
wr_strobe  in  1  write one word of the current sector
wr_data  in  DATA_W  word to write
wr_abort  in  1  discard the partially written sector
wr_ready  out  1  a free slot is available for writing (= !full)
wr_done  out  1  one-cycle pulse after a sector is committed
wr_cnt  out  log2(SECTOR_BYTES)  word index of the next write
rd_addr  in  log2(SECTOR_BYTES)  word address within the head sector
rd_data  out  DATA_W  registered read data
rd_valid  out  1  at least one committed sector is present (= !empty)
rd_release  in  1  free the head sector
count  out  log2(SLOTS)+1  number of committed sectors

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rstn low asynchronously clears: wr_slot, rd_slot, wr_cnt, count, rd_data, wr_done. All become 0.
  - Memory contents are not reset.
  - Reset asserted mid-sector discards the partial sector.
- Storage:
  - SLOTS*SECTOR_BYTES words.
  - Physical address is {slot, word}.
  - Must infer block RAM: one write port, one read port.
- Write side:
  - A strobe is accepted when wr_strobe=1, wr_ready=1 and wr_abort=0.
  - Accepted strobe: mem[{wr_slot,wr_cnt}] <= wr_data, then wr_cnt++.
  - Strobe while wr_ready=0: the word is dropped and no state changes.
  - Accepted strobe with wr_cnt == SECTOR_BYTES-1 commits the sector:
    - wr_cnt wraps to 0.
    - wr_slot increments modulo SLOTS.
    - count increments.
    - wr_done=1 on the next cycle only.
  - wr_abort=1: wr_cnt <= 0, wr_slot unchanged. Abort takes priority over a same-cycle strobe. Abort with wr_cnt=0 is a no-op.
- Read side:
  - Every cycle, rd_data <= mem[{rd_slot,rd_addr}]. Latency is 1 clock.
  - While empty, rd_data still tracks memory at rd_slot (stale content); rd_valid=0.
  - rd_release while count>0: rd_slot increments modulo SLOTS, count decrements.
  - rd_release while count=0 is ignored.
  - After a release, the read in the same cycle still uses the old rd_slot; the next cycle uses the new one.
- Flags and boundary cases:
  - full when count==SLOTS; empty when count==0.
  - Commit and release in the same cycle: count unchanged, both pointers advance.
  - When full, wr_cnt is always 0, because writing only starts when a slot is free.
  - Write and read hitting the same physical address in one cycle (only possible while empty): read-first, so rd_data returns the old content.
  - Pointer wrap: the slot after SLOTS-1 is 0.

Optional Feature:
Macro SECTOR_RING_OVF_EN.
- Defined, adds two outputs:
  - ovf (1 bit): sticky, set by any strobe dropped while full; cleared by reset or by wr_abort.
  - ovf_cnt (16 bits): saturating count of dropped words; same clearing rule.
- Undefined: the ports and logic are absent, and dropped words leave no trace.

Test Plan:
- Reset, then write 512 words 0x00..0xFF,0x00..0xFF:
  - wr_done pulses exactly once, one cycle after the 512th strobe.
  - count=1, rd_valid=1.
  - rd_addr=0x1FF yields rd_data=0xFF one clock later.
- Fill 4 sectors with fill bytes 0xA1..0xA4:
  - count=4, wr_ready=0.
  - A further strobe of 0x55 is dropped; ovf=1 if enabled.
  - Read returns 0xA1 at any address.
  - After rd_release, count=3, wr_ready=1, and reads return 0xA2.
- Write 100 words, then assert wr_abort together with a strobe:
  - wr_cnt=0 and count unchanged.
  - The next full sector is committed into the same slot.
- Hold count=2. On the cycle a sector commits, pulse rd_release:
  - count stays 2.
  - rd_slot and wr_slot both advance.
- Run 9 sector write/release cycles with SLOTS=4:
  - Pointers wrap correctly.
  - Each sector reads back its own fill pattern.
- Assert rstn low mid-sector (wr_cnt=37, count=2):
  - Immediately count=0, wr_cnt=0, rd_valid=0, wr_ready=1, without waiting for a clock edge.

Source files
------------

// File: rtl/sector_ring_buffer.sv
// sector_ring_buffer: ring of SLOTS sector buffers between the SD controller (write) and the core disk port (read).
// Defining SECTOR_RING_OVF_EN adds sticky drop tracking outputs ovf / ovf_cnt.
module sector_ring_buffer #(
    parameter int SLOTS        = 4,
    parameter int SECTOR_BYTES = 512,
    parameter int DATA_W       = 8
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            wr_strobe,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            wr_abort,
    output logic                            wr_ready,
    output logic                            wr_done,
    output logic [$clog2(SECTOR_BYTES)-1:0] wr_cnt,
    input  logic [$clog2(SECTOR_BYTES)-1:0] rd_addr,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            rd_valid,
    input  logic                            rd_release,
    output logic [$clog2(SLOTS):0]          count
`ifdef SECTOR_RING_OVF_EN
    ,
    output logic                            ovf,
    output logic [15:0]                     ovf_cnt
`endif
);

    localparam int AW = $clog2(SECTOR_BYTES);
    localparam int SW = $clog2(SLOTS);
    localparam int CW = SW + 1;
    localparam int DEPTH = SLOTS * SECTOR_BYTES;

    localparam logic [AW-1:0] LAST_WORD = AW'(SECTOR_BYTES - 1);
    localparam logic [AW-1:0] WORD_ONE  = AW'(1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_FULL  = CW'(SLOTS);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic [SW-1:0]     wr_slot_r;
    logic [SW-1:0]     rd_slot_r;
    logic [AW-1:0]     wr_cnt_r;
    logic [CW-1:0]     count_r;
    logic              wr_done_r;
    logic [DATA_W-1:0] rd_data_r;

    logic [SW-1:0]     wr_slot_nxt_s;
    logic [SW-1:0]     rd_slot_nxt_s;
    logic [AW-1:0]     wr_cnt_nxt_s;
    logic [CW-1:0]     count_nxt_s;

    logic              full_s;
    logic              empty_s;
    logic              accept_s;
    logic              commit_s;
    logic              release_s;
    logic [SW+AW-1:0]  wr_addr_s;
    logic [SW+AW-1:0]  rd_addr_s;

    assign full_s    = (count_r == CNT_FULL);
    assign empty_s   = (count_r == CNT_ZERO);
    assign accept_s  = wr_strobe & ~full_s & ~wr_abort;
    assign commit_s  = accept_s & (wr_cnt_r == LAST_WORD);
    assign release_s = rd_release & ~empty_s;
    assign wr_addr_s = {wr_slot_r, wr_cnt_r};
    assign rd_addr_s = {rd_slot_r, rd_addr};

    // Next-state for the write pointer, read pointer and committed-sector count.
    always_comb begin
        wr_cnt_nxt_s  = wr_cnt_r;
        wr_slot_nxt_s = wr_slot_r;
        rd_slot_nxt_s = rd_slot_r;
        count_nxt_s   = count_r;

        if (wr_abort) begin
            wr_cnt_nxt_s = '0;
        end else if (accept_s) begin
            if (commit_s) begin
                wr_cnt_nxt_s  = '0;
                wr_slot_nxt_s = wr_slot_r + SLOT_ONE;
            end else begin
                wr_cnt_nxt_s = wr_cnt_r + WORD_ONE;
            end
        end else begin
            wr_cnt_nxt_s = wr_cnt_r;
        end

        if (release_s) begin
            rd_slot_nxt_s = rd_slot_r + SLOT_ONE;
        end else begin
            rd_slot_nxt_s = rd_slot_r;
        end

        // A commit and a release in the same cycle cancel out in the count.
        case ({commit_s, release_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, count and commit-pulse registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_slot_r <= '0;
            rd_slot_r <= '0;
            wr_cnt_r  <= '0;
            count_r   <= '0;
            wr_done_r <= 1'b0;
        end else begin
            wr_slot_r <= wr_slot_nxt_s;
            rd_slot_r <= rd_slot_nxt_s;
            wr_cnt_r  <= wr_cnt_nxt_s;
            count_r   <= count_nxt_s;
            wr_done_r <= commit_s;
        end
    end

    // Sector storage write port; kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem[wr_addr_s] <= wr_data;
        end
    end

    // Registered read port; on a same-address collision the old word is returned.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_r <= '0;
        end else begin
            rd_data_r <= mem[rd_addr_s];
        end
    end

    assign wr_ready = ~full_s;
    assign rd_valid = ~empty_s;
    assign wr_done  = wr_done_r;
    assign wr_cnt   = wr_cnt_r;
    assign count    = count_r;
    assign rd_data  = rd_data_r;

`ifdef SECTOR_RING_OVF_EN
    logic        ovf_r;
    logic [15:0] ovf_cnt_r;
    logic        drop_s;

    assign drop_s = wr_strobe & full_s;

    // Sticky drop flag and saturating drop counter; abort clears both.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_r     <= 1'b0;
            ovf_cnt_r <= 16'd0;
        end else if (wr_abort) begin
            ovf_r     <= 1'b0;
            ovf_cnt_r <= 16'd0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
            if (ovf_cnt_r != 16'hFFFF) begin
                ovf_cnt_r <= ovf_cnt_r + 16'd1;
            end
        end
    end

    assign ovf     = ovf_r;
    assign ovf_cnt = ovf_cnt_r;
`endif

endmodule

// File: tb/tb_sector_ring_buffer.sv
// Self-checking bench for sector_ring_buffer: sector-queue reference model, directed steps plus random traffic.
// Build with SECTOR_RING_OVF_EN defined to also exercise ovf / ovf_cnt.
module tb_sector_ring_buffer;

    localparam int SLOTS = 4;
    localparam int SB    = 512;

    logic       clk;
    logic       rstn;
    logic       wr_strobe;
    logic [7:0] wr_data;
    logic       wr_abort;
    logic       wr_ready;
    logic       wr_done;
    logic [8:0] wr_cnt;
    logic [8:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_release;
    logic [2:0] count;
`ifdef SECTOR_RING_OVF_EN
    logic        ovf;
    logic [15:0] ovf_cnt;
`endif

    sector_ring_buffer #(.SLOTS(SLOTS), .SECTOR_BYTES(SB), .DATA_W(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .wr_strobe  (wr_strobe),
        .wr_data    (wr_data),
        .wr_abort   (wr_abort),
        .wr_ready   (wr_ready),
        .wr_done    (wr_done),
        .wr_cnt     (wr_cnt),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_release (rd_release),
        .count      (count)
`ifdef SECTOR_RING_OVF_EN
        ,
        .ovf        (ovf),
        .ovf_cnt    (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: committed sectors as a FIFO of byte arrays plus the sector being assembled.
    typedef logic [7:0] sector_t [SB];
    sector_t q[$];
    sector_t part;
    int      part_len;
    int      ovf_m;
    int      ovf_cnt_m;
    int      n_assert;
    int      n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        part_len  = 0;
        ovf_m     = 0;
        ovf_cnt_m = 0;
    endtask

    // One clock: drive inputs, advance the model, then check every observable output.
    task automatic cyc(input logic s, input logic [7:0] d, input logic ab, input logic rl, input logic [8:0] a);
        logic [7:0] exp_rd;
        bit         rd_ok;
        bit         commit;
        bit         was_full;
        wr_strobe  = s;
        wr_data    = d;
        wr_abort   = ab;
        rd_release = rl;
        rd_addr    = a;
        rd_ok      = (q.size() > 0);
        exp_rd     = 8'h00;
        if (rd_ok) exp_rd = q[0][a];
        was_full = (q.size() == SLOTS);
        commit   = 1'b0;
        if (ab) begin
            part_len  = 0;
            ovf_m     = 0;
            ovf_cnt_m = 0;
        end else if (s && !was_full) begin
            part[part_len] = d;
            if (part_len == SB - 1) begin
                commit   = 1'b1;
                part_len = 0;
            end else begin
                part_len++;
            end
        end else if (s && was_full) begin
            ovf_m = 1;
            if (ovf_cnt_m < 65535) ovf_cnt_m++;
        end
        if (rl && q.size() > 0) q.delete(0);
        if (commit) q.push_back(part);
        @(posedge clk);
        #1;
        chk("wr_cnt", 32'(wr_cnt), 32'(part_len));
        chk("count", 32'(count), 32'(q.size()));
        chk("wr_done", 32'(wr_done), 32'(commit));
        chk("wr_ready", 32'(wr_ready), 32'(q.size() < SLOTS));
        chk("rd_valid", 32'(rd_valid), 32'(q.size() > 0));
        if (rd_ok) chk("rd_data", 32'(rd_data), 32'(exp_rd));
`ifdef SECTOR_RING_OVF_EN
        chk("ovf", 32'(ovf), 32'(ovf_m));
        chk("ovf_cnt", 32'(ovf_cnt), 32'(ovf_cnt_m));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 9'($urandom));
    endtask

    // mode 0: constant fill, 1: counting pattern, 2: random bytes
    task automatic wr_words(input int n, input int mode, input logic [7:0] fill);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            if (mode == 0) d = fill;
            else if (mode == 1) d = 8'(i);
            else d = 8'($urandom);
            cyc(1'b1, d, 1'b0, 1'b0, 9'($urandom));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() > 0; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 9'($urandom));
        chk("drain_empty", 32'(count), 32'd0);
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        model_reset();
        rstn       = 1'b0;
        wr_strobe  = 1'b0;
        wr_data    = 8'h00;
        wr_abort   = 1'b0;
        rd_release = 1'b0;
        rd_addr    = 9'd0;

        // Reset state
        #3;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("rst_wr_done", 32'(wr_done), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // First sector 0x00..0xFF twice; wr_done is checked every cycle by cyc
        wr_words(SB, 1, 8'h00);
        chk("s1_count", 32'(count), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 9'h1FF);
        chk("s1_rd_1ff", 32'(rd_data), 32'hFF);
        chk("s1_done_once", 32'(wr_done), 32'd0);
        drain();

        // Fill all slots with A1..A4 and overflow by one word
        for (int k = 0; k < 4; k++) wr_words(SB, 0, 8'hA1 + 8'(k));
        chk("full_count", 32'(count), 32'd4);
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 9'd0);
        chk("full_drop_cnt", 32'(wr_cnt), 32'd0);
        chk("full_read_a1", 32'(rd_data), 32'hA1);
        idle(4);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 9'd7);
        chk("rel_count", 32'(count), 32'd3);
        chk("rel_wr_ready", 32'(wr_ready), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 9'd300);
        chk("rel_read_a2", 32'(rd_data), 32'hA2);
        drain();

        // Partial sector then abort with a same-cycle strobe
        wr_words(100, 2, 8'h00);
        cyc(1'b1, 8'h77, 1'b1, 1'b0, 9'd0);
        chk("abort_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("abort_count", 32'(count), 32'd0);
        wr_words(SB, 2, 8'h00);
        idle(6);
        drain();

        // count held at 2 while a commit and a release coincide
        wr_words(SB, 0, 8'hB1);
        wr_words(SB, 0, 8'hB2);
        wr_words(SB - 1, 0, 8'hB3);
        cyc(1'b1, 8'hB3, 1'b0, 1'b1, 9'd0);
        chk("coinc_count", 32'(count), 32'd2);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 9'd99);
        chk("coinc_head_b2", 32'(rd_data), 32'hB2);
        drain();
        wr_words(SB, 0, 8'hB4);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 9'd1);
        chk("coinc_wr_adv", 32'(rd_data), 32'hB4);
        drain();

        // Nine write/release rounds to wrap both pointers
        for (int k = 0; k < 9; k++) begin
            wr_words(SB, 0, 8'($urandom));
            idle(3);
            cyc(1'b0, 8'h00, 1'b0, 1'b1, 9'($urandom));
        end
        chk("wrap_empty", 32'(count), 32'd0);

        // Random mixed traffic
        for (int i = 0; i < 4000; i++) begin
            cyc(1'($urandom_range(0, 9) < 8), 8'($urandom), 1'($urandom_range(0, 999) == 0),
                1'($urandom_range(0, 449) == 0), 9'($urandom));
        end
        drain();
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 9'd0);

        // Asynchronous reset mid-sector
        wr_words(SB, 2, 8'h00);
        wr_words(SB, 2, 8'h00);
        wr_words(37, 2, 8'h00);
        chk("pre_rst_wr_cnt", 32'(wr_cnt), 32'd37);
        chk("pre_rst_count", 32'(count), 32'd2);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        chk("arst_wr_ready", 32'(wr_ready), 32'd1);
        chk("arst_wr_done", 32'(wr_done), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        wr_words(SB, 2, 8'h00);
        idle(5);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
